// File: rtl/pwm_shadow_loader.sv
// Double-buffered LED PWM register decoder: register writes land in a per-channel
// shadow set that is copied to the active set only at a PWM period wrap.
module pwm_shadow_loader #(
  parameter int          CHANNELS  = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h06,
  parameter logic [7:0]  ALL_ADDR  = 8'hFA
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               write_register_id_i,
  input  logic [7:0]               write_register_value_i,
  input  logic                     write_enable_i,
  input  logic [11:0]              counter_i,
  output logic [CHANNELS-1:0]      pwm_full_on_o,
  output logic [CHANNELS-1:0]      pwm_full_off_o,
  output logic [12*CHANNELS-1:0]   pwm_on_count_o,
  output logic [12*CHANNELS-1:0]   pwm_off_count_o,
  output logic                     pending_o,
  output logic                     commit_o
);

  localparam int         CH_W    = $clog2(CHANNELS);
  localparam logic [8:0] CH_SPAN = 9'(4 * CHANNELS);

  // Byte-lane merge helpers for the 12-bit counts.
  function automatic logic [11:0] merge_low(input logic [11:0] cur, input logic [7:0] b);
    return {cur[11:8], b};
  endfunction

  function automatic logic [11:0] merge_high(input logic [11:0] cur, input logic [7:0] b);
    return {b[3:0], cur[7:0]};
  endfunction

  logic [11:0]         counter_q_r;
  logic                pending_r;
  logic                commit_r;

  logic [8:0]          base_off_s;
  logic [8:0]          all_off_s;
  logic                ch_hit_s;
  logic                all_hit_s;
  logic                accept_s;
  logic [1:0]          k_s;
  logic [CH_W-1:0]     ch_idx_s;
  logic [CHANNELS-1:0] wr_sel_s;
  logic                wrap_s;
  logic                commit_now_s;

  // Address decode: per-channel window, broadcast window and byte offset.
  always_comb begin
    base_off_s = {1'b0, write_register_id_i} - {1'b0, BASE_ADDR};
    all_off_s  = {1'b0, write_register_id_i} - {1'b0, ALL_ADDR};
    ch_hit_s   = write_enable_i && (base_off_s < CH_SPAN);
    all_hit_s  = write_enable_i && (all_off_s < 9'd4);
    accept_s   = ch_hit_s || all_hit_s;
    ch_idx_s   = base_off_s[CH_W+1:2];
    if (all_hit_s) begin
      k_s = all_off_s[1:0];
    end else begin
      k_s = base_off_s[1:0];
    end
  end

  // Channel select vector: one channel for a direct write, all for broadcast.
  always_comb begin
    wr_sel_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel_s[i] = all_hit_s || (ch_hit_s && (ch_idx_s == CH_W'(i)));
    end
  end

  // A wrap is the first cycle the counter reads 0; a held 0 is not a new wrap.
  always_comb begin
    wrap_s       = (counter_i == 12'd0) && (counter_q_r != 12'd0);
    commit_now_s = wrap_s && pending_r;
  end

  // Counter history, pending flag and commit pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_q_r <= 12'd0;
      pending_r   <= 1'b0;
      commit_r    <= 1'b0;
    end else begin
      counter_q_r <= counter_i;
      commit_r    <= commit_now_s;
      if (accept_s) begin
        pending_r <= 1'b1;
      end else if (commit_now_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign pending_o = pending_r;
  assign commit_o  = commit_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [11:0] sh_on_r;
    logic [11:0] sh_off_r;
    logic        sh_fon_r;
    logic        sh_foff_r;
    logic [11:0] act_on_r;
    logic [11:0] act_off_r;
    logic        act_fon_r;
    logic        act_foff_r;

    // Shadow takes writes; active copies the pre-edge shadow on a commit.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sh_on_r    <= 12'd0;
        sh_off_r   <= 12'd0;
        sh_fon_r   <= 1'b0;
        sh_foff_r  <= 1'b1;
        act_on_r   <= 12'd0;
        act_off_r  <= 12'd0;
        act_fon_r  <= 1'b0;
        act_foff_r <= 1'b1;
      end else begin
        if (wr_sel_s[g]) begin
          case (k_s)
            2'd0: sh_on_r <= merge_low(sh_on_r, write_register_value_i);
            2'd1: begin
              sh_on_r  <= merge_high(sh_on_r, write_register_value_i);
              sh_fon_r <= write_register_value_i[4];
            end
            2'd2: sh_off_r <= merge_low(sh_off_r, write_register_value_i);
            2'd3: begin
              sh_off_r  <= merge_high(sh_off_r, write_register_value_i);
              sh_foff_r <= write_register_value_i[4];
            end
            default: sh_on_r <= sh_on_r;
          endcase
        end
        if (commit_now_s) begin
          act_on_r   <= sh_on_r;
          act_off_r  <= sh_off_r;
          act_fon_r  <= sh_fon_r;
          act_foff_r <= sh_foff_r;
        end
      end
    end

    assign pwm_on_count_o[12*g +: 12]  = act_on_r;
    assign pwm_off_count_o[12*g +: 12] = act_off_r;
    assign pwm_full_on_o[g]            = act_fon_r;
    assign pwm_full_off_o[g]           = act_foff_r;
  end

endmodule

// File: tb/tb_pwm_shadow_loader.sv
// Directed bench for pwm_shadow_loader: expected active sets are queued at stimulus
// time and a monitor compares them whenever commit_o pulses.
module tb_pwm_shadow_loader;

  typedef struct packed {
    logic [15:0]  fon;
    logic [15:0]  foff;
    logic [191:0] on;
    logic [191:0] off;
  } st_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   addr = 8'd0;
  logic [7:0]   data = 8'd0;
  logic         we = 1'b0;
  logic [11:0]  cnt = 12'd0;
  logic [15:0]  full_on, full_off;
  logic [191:0] on_cnt, off_cnt;
  logic         pending, commit;

  int vectors = 0;
  int miscompares = 0;
  int commits_seen = 0;
  int exp_commits = 0;
  st_t exp_q[$];
  st_t mon_e;
  st_t rs, e;

  pwm_shadow_loader dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .write_register_id_i    (addr),
    .write_register_value_i (data),
    .write_enable_i         (we),
    .counter_i              (cnt),
    .pwm_full_on_o          (full_on),
    .pwm_full_off_o         (full_off),
    .pwm_on_count_o         (on_cnt),
    .pwm_off_count_o        (off_cnt),
    .pending_o              (pending),
    .commit_o               (commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_state(input string name, input st_t x);
    chk({name, " full_on"},  {176'd0, full_on},  {176'd0, x.fon});
    chk({name, " full_off"}, {176'd0, full_off}, {176'd0, x.foff});
    chk({name, " on_count"},  on_cnt,  x.on);
    chk({name, " off_count"}, off_cnt, x.off);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic expect_commit(input st_t x);
    exp_q.push_back(x);
    exp_commits++;
  endtask

  task automatic do_wrap();
    cnt = 12'd4095;
    tick();
    cnt = 12'd0;
    tick();
    cnt = 12'd1;
    tick();
    tick();
  endtask

  // Monitor: every commit pulse must match the next queued expected active set.
  always @(negedge clk) begin
    if (!rst && commit) begin
      commits_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_commit: commit_o=1 with no commit expected");
      end else begin
        mon_e = exp_q.pop_front();
        cmp_state("commit", mon_e);
      end
    end
  end

  initial begin
    rs.fon  = 16'h0000;
    rs.foff = 16'hFFFF;
    rs.on   = 192'd0;
    rs.off  = 192'd0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    cmp_state("reset", rs);
    chk("reset pending", {191'd0, pending}, 192'd0);
    chk("reset commit",  {191'd0, commit},  192'd0);

    // Channel 0 write
    cnt = 12'd100;
    tick();
    wr(8'h06, 8'h99);
    wr(8'h07, 8'h01);
    wr(8'h08, 8'hCC);
    wr(8'h09, 8'h04);
    tick();
    cmp_state("ch0 pre-wrap", rs);
    chk("ch0 pending", {191'd0, pending}, 192'd1);
    e = rs;
    e.on[11:0]  = 12'h199;
    e.off[11:0] = 12'h4CC;
    e.foff[0]   = 1'b0;
    expect_commit(e);
    do_wrap();
    cmp_state("ch0 post-wrap", e);
    chk("ch0 pending cleared", {191'd0, pending}, 192'd0);
    chk("ch0 commits", 192'(commits_seen), 192'(exp_commits));

    // Broadcast: OFF_H=0 clears ch0 off[11:8], ON_H=0x10 clears ch0 on[11:8]
    wr(8'hFD, 8'h00);
    wr(8'hFB, 8'h10);
    e.fon       = 16'hFFFF;
    e.foff      = 16'h0000;
    e.on[11:0]  = 12'h099;
    e.off[11:0] = 12'h0CC;
    expect_commit(e);
    do_wrap();
    cmp_state("broadcast", e);
    chk("broadcast commits", 192'(commits_seen), 192'(exp_commits));

    // Coincident write on the wrap cycle
    wr(8'h06, 8'h55);
    cnt = 12'd4095;
    tick();
    e.on[11:0] = 12'h055;
    expect_commit(e);
    cnt  = 12'd0;
    addr = 8'h45;
    data = 8'h10;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    cmp_state("coincident first", e);
    chk("coincident pending", {191'd0, pending}, 192'd1);
    tick();
    tick();
    tick();
    chk("coincident pending held", {191'd0, pending}, 192'd1);
    cnt = 12'd7;
    tick();
    e.foff = 16'h8000;
    expect_commit(e);
    do_wrap();
    cmp_state("coincident second", e);
    chk("coincident commits", 192'(commits_seen), 192'(exp_commits));

    // Ignored addresses, then held zero
    cnt = 12'd100;
    tick();
    wr(8'h00, 8'hFF);
    wr(8'h46, 8'hFF);
    wr(8'hFE, 8'hFF);
    tick();
    chk("ignored pending", {191'd0, pending}, 192'd0);
    do_wrap();
    chk("ignored no commit", 192'(commits_seen), 192'(exp_commits));
    wr(8'h0A, 8'h12);
    e.on[23:12] = 12'h012;
    expect_commit(e);
    cnt = 12'd4095;
    tick();
    cnt = 12'd0;
    for (int i = 0; i < 50; i++) tick();
    cnt = 12'd1;
    tick();
    tick();
    cmp_state("held zero", e);
    chk("held zero commits", 192'(commits_seen), 192'(exp_commits));

    // Reset mid-pending
    cnt = 12'd100;
    tick();
    wr(8'h0A, 8'hFF);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    cmp_state("midreset", rs);
    chk("midreset pending", {191'd0, pending}, 192'd0);
    do_wrap();
    cmp_state("midreset post-wrap", rs);
    chk("midreset commits", 192'(commits_seen), 192'(exp_commits));
    chk("queue drained", 192'(exp_q.size()), 192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
